// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel between the fetch stage and imem.
// One request may be outstanding; rvalid returns at least a cycle after gnt.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, imem request sequencing and the
// instruction buffer feeding the Fetch->Decode register.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_StallF,
    input  logic            i_StallD,
    input  logic            i_PCSrcE,
    input  logic [XLEN-1:0] i_PCTargetE,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] o_instrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F,
    output logic            o_validF,
    output logic            o_FlushD_CLR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;

    assign target   = i_PCTargetE & ~XLEN'(3);
    assign pc_plus4 = pc_q + XLEN'(4);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (i_PCSrcE) begin
                    pc_d = target;
                    if (imem.imem_gnt) state_d = S_KILL;
                end else if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_PCSrcE) begin
                    pc_d    = target;
                    state_d = imem.imem_rvalid ? S_REQ : S_KILL;
                end else if (imem.imem_rvalid) begin
                    buf_d   = imem.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_PCSrcE) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!i_StallF) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_KILL: begin
                // the stale response is consumed here and never buffered
                if (i_PCSrcE) pc_d = target;
                if (imem.imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = pc_q;

    assign o_instrF     = buf_q;
    assign o_PCF        = pc_q;
    assign o_PCPlus4F   = pc_plus4;
    assign o_validF     = (state_q == S_HOLD);
    assign o_FlushD_CLR = i_PCSrcE | (!o_validF & !i_StallD);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for reset
// and address wrap, then random traffic against a transaction-level model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        sfA, sdA, brA;
    logic [31:0] tgA;
    logic [31:0] insA, pcA, p4A;
    logic        vA, flA;

    logic        sfB, sdB, brB;
    logic [31:0] tgB;
    logic [31:0] insB, pcB, p4B;
    logic        vB, flB;

    fetch_unit_if imA ();
    fetch_unit_if imB ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dutA (
        .i_clk(clk), .i_rstn(rstn),
        .i_StallF(sfA), .i_StallD(sdA),
        .i_PCSrcE(brA), .i_PCTargetE(tgA),
        .imem(imA),
        .o_instrF(insA), .o_PCF(pcA), .o_PCPlus4F(p4A),
        .o_validF(vA), .o_FlushD_CLR(flA)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dutB (
        .i_clk(clk), .i_rstn(rstn),
        .i_StallF(sfB), .i_StallD(sdB),
        .i_PCSrcE(brB), .i_PCTargetE(tgB),
        .imem(imB),
        .o_instrF(insB), .o_PCF(pcB), .o_PCPlus4F(p4B),
        .o_validF(vB), .o_FlushD_CLR(flB)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        sf, sd, br;
        logic [31:0] tg;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        e_req, e_val;
        logic [31:0] e_pc, e_ins;
        logic        e_fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic sf, sd, br, input logic [31:0] tg,
        input logic gnt, rv, input logic [31:0] rd,
        input logic e_req, e_val, input logic [31:0] e_pc, e_ins,
        input logic e_fl);
        vec_t v;
        v.sf = sf; v.sd = sd; v.br = br; v.tg = tg;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_val = e_val;
        v.e_pc = e_pc; v.e_ins = e_ins; v.e_fl = e_fl;
        return v;
    endfunction

    // reference model state: what the fetch stage owes the pipeline
    bit          m_started, m_busy, m_drop, m_valid;
    logic [31:0] m_pc, m_instr;
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_a(input string tag, input logic e_req,
                           input logic e_val, input logic [31:0] e_pc,
                           input logic [31:0] e_ins, input logic e_fl);
        chk({tag, " req"}, 32'(imA.imem_req), 32'(e_req));
        if (e_req) chk({tag, " addr"}, imA.imem_addr, e_pc);
        chk({tag, " valid"}, 32'(vA), 32'(e_val));
        chk({tag, " pc"}, pcA, e_pc);
        chk({tag, " pc4"}, p4A, e_pc + 32'd4);
        chk({tag, " flush"}, 32'(flA), 32'(e_fl));
        if (e_val) chk({tag, " instr"}, insA, e_ins);
    endtask

    initial begin
        logic [31:0] tgm;
        sfA = 0; sdA = 0; brA = 0; tgA = 0;
        sfB = 0; sdB = 0; brB = 0; tgB = 0;
        imA.imem_gnt = 0; imA.imem_rvalid = 0; imA.imem_rdata = 0;
        imB.imem_gnt = 0; imB.imem_rvalid = 0; imB.imem_rdata = 0;

        //         sf sd br tg            gnt rv rd             req val pc           ins            fl
        tbl.push_back(mk(0,0,0,32'h0,       0,0,32'h0,          0,0,32'h000,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h000,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'hAAAA_0000,  0,0,32'h000,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0,32'h0,          0,1,32'h000,32'hAAAA_0000,  0));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h004,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'hBBBB_0004,  0,0,32'h004,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0,32'h0,          0,1,32'h004,32'hBBBB_0004,  0));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h008,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'hCCCC_0008,  0,0,32'h008,32'h0,          1));
        tbl.push_back(mk(1,1,0,32'h0,       1,0,32'h0,          0,1,32'h008,32'hCCCC_0008,  0));
        tbl.push_back(mk(1,1,0,32'h0,       1,0,32'h0,          0,1,32'h008,32'hCCCC_0008,  0));
        tbl.push_back(mk(1,1,0,32'h0,       1,0,32'h0,          0,1,32'h008,32'hCCCC_0008,  0));
        tbl.push_back(mk(0,0,0,32'h0,       0,0,32'h0,          0,1,32'h008,32'hCCCC_0008,  0));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h00C,32'h0,          1));
        tbl.push_back(mk(0,0,1,32'h103,     0,0,32'h0,          0,0,32'h00C,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0,32'h0,          0,0,32'h100,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'hDEAD_BEEF,  0,0,32'h100,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h100,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'h1111_0100,  0,0,32'h100,32'h0,          1));
        tbl.push_back(mk(1,0,1,32'h200,     0,0,32'h0,          0,1,32'h100,32'h1111_0100,  1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'hBAD0_BAD0,  1,0,32'h200,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       1,0,32'h0,          1,0,32'h200,32'h0,          1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1,32'h2222_0200,  0,0,32'h200,32'h0,          1));
        tbl.push_back(mk(1,0,0,32'h0,       0,0,32'h0,          0,1,32'h200,32'h2222_0200,  0));

        repeat (2) @(negedge clk);
        #1;
        check_a("rst", 0, 0, 32'h0, 32'h0, 1);
        chk("rstB pc", pcB, 32'hFFFF_FFFC);

        foreach (tbl[i]) begin
            @(negedge clk);
            if (i == 0) rstn = 1;
            sfA = tbl[i].sf; sdA = tbl[i].sd;
            brA = tbl[i].br; tgA = tbl[i].tg;
            imA.imem_gnt = tbl[i].gnt;
            imA.imem_rvalid = tbl[i].rv;
            imA.imem_rdata = tbl[i].rd;
            #1;
            check_a($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_val,
                    tbl[i].e_pc, tbl[i].e_ins, tbl[i].e_fl);
        end

        // consume, issue a request, then reset while it is outstanding
        @(negedge clk);
        sfA = 0; imA.imem_rvalid = 0; imA.imem_gnt = 0;
        @(negedge clk);
        imA.imem_gnt = 1;
        #1 chk("pre-rst req", 32'(imA.imem_req), 32'd1);
        chk("pre-rst addr", imA.imem_addr, 32'h204);
        @(negedge clk);
        imA.imem_gnt = 0;
        #1 chk("wait req", 32'(imA.imem_req), 32'd0);
        @(negedge clk);
        rstn = 0;
        #1 check_a("midrst", 0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        rstn = 1;
        #1 check_a("idle", 0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        imA.imem_gnt = 1;
        #1 check_a("first", 1, 0, 32'h0, 32'h0, 1);

        // wrap-around fetch on the second instance
        imB.imem_gnt = 1;
        chk("wrapB req", 32'(imB.imem_req), 32'd1);
        chk("wrapB addr", imB.imem_addr, 32'hFFFF_FFFC);
        chk("wrapB pc4", p4B, 32'h0);
        @(negedge clk);
        imA.imem_gnt = 0;
        imB.imem_gnt = 0; imB.imem_rvalid = 1; imB.imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        imB.imem_rvalid = 0;
        #1 chk("wrapB valid", 32'(vB), 32'd1);
        chk("wrapB instr", insB, 32'h5555_AAAA);
        chk("wrapB pcf", pcB, 32'hFFFF_FFFC);
        @(negedge clk);
        #1 chk("wrapB req2", 32'(imB.imem_req), 32'd1);
        chk("wrapB addr2", imB.imem_addr, 32'h0);
        chk("wrapB pc4_2", p4B, 32'h4);

        // randomized traffic against the model
        @(negedge clk);
        rstn = 0;
        imA.imem_gnt = 0; imA.imem_rvalid = 0;
        m_started = 0; m_busy = 0; m_drop = 0; m_valid = 0;
        m_pc = 32'h0; m_instr = 32'h0;
        mem_pend = 0; mem_cnt = 0; mem_addr = 0;
        @(negedge clk);
        rstn = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c != 0) @(negedge clk);
            sfA = ($urandom_range(0, 2) == 0);
            sdA = ($urandom_range(0, 3) == 0);
            brA = ($urandom_range(0, 7) == 0);
            tgA = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : ($urandom & 32'h0000_0FFF);
            imA.imem_gnt = 1'($urandom_range(0, 1));
            if (mem_pend && mem_cnt == 0) begin
                imA.imem_rvalid = 1;
                imA.imem_rdata = memf(mem_addr);
            end else if (!mem_pend && $urandom_range(0, 15) == 0) begin
                imA.imem_rvalid = 1;
                imA.imem_rdata = $urandom;
            end else begin
                imA.imem_rvalid = 0;
                imA.imem_rdata = $urandom;
            end
            #1;
            check_a("rnd", m_started && !m_busy && !m_valid, m_valid,
                    m_pc, m_instr, brA | (!m_valid & !sdA));
            if (m_valid) chk("rnd owner", insA, memf(pcA));

            tgm = tgA & 32'hFFFF_FFFC;
            if (!m_started) begin
                m_started = 1;
            end else if (m_valid) begin
                if (brA) begin
                    m_pc = tgm; m_valid = 0;
                end else if (!sfA) begin
                    m_pc = m_pc + 32'd4; m_valid = 0;
                end
            end else if (!m_busy) begin
                if (imA.imem_gnt) begin
                    m_busy = 1; m_drop = brA;
                end
                if (brA) m_pc = tgm;
            end else begin
                if (imA.imem_rvalid) begin
                    m_busy = 0;
                    if (!m_drop && !brA) begin
                        m_valid = 1; m_instr = imA.imem_rdata;
                    end
                end else if (brA) begin
                    m_drop = 1;
                end
                if (brA) m_pc = tgm;
            end

            if (mem_pend && imA.imem_rvalid) mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (imA.imem_req && imA.imem_gnt) begin
                mem_pend = 1;
                mem_addr = imA.imem_addr;
                mem_cnt = $urandom_range(0, 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
